// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: bus-ownership encoding and default bus widths.
package mem_pkg;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } own_e;

  localparam int unsigned DEF_AW = 16;
  localparam int unsigned DEF_DW = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Single memory port shared between the cpu (priority owner) and a DMA engine, with
// bounded DMA starvation (MAX_WAIT) and bounded DMA bursts (BURST_LEN).
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic          CLK,
  input  logic          R,
  input  logic          C_REQ,
  input  logic          C_WE,
  input  logic [AW-1:0] C_ADDR,
  input  logic [DW-1:0] C_DIN,
  output logic          C_GNT,
  output logic          C_RDY,
  input  logic          D_REQ,
  input  logic          D_WE,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_DIN,
  output logic          D_GNT,
  output logic [DW-1:0] RD_DATA,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_DIN,
  input  logic [DW-1:0] MEM_DOUT
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam int unsigned BW = $clog2(BURST_LEN + 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

  own_e          own_q, own_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          c_gnt, d_gnt;

  // Grants are combinational so the access completes in the requesting cycle.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!R) begin
      if (own_q == OWN_C) begin
        c_gnt = C_REQ;
        d_gnt = ~C_REQ & D_REQ;
      end else begin
        d_gnt = D_REQ;
        c_gnt = ~D_REQ & C_REQ;
      end
    end
  end

  always_comb begin
    MEM_ADDR = C_ADDR;
    MEM_DIN  = '0;
    MEM_WE   = 1'b0;
    if (c_gnt) begin
      MEM_DIN = C_DIN;
      MEM_WE  = C_WE;
    end else if (d_gnt) begin
      MEM_ADDR = D_ADDR;
      MEM_DIN  = D_DIN;
      MEM_WE   = D_WE;
    end
  end

  always_comb begin
    own_d       = own_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    if (own_q == OWN_C) begin
      // Only a blocked D counts toward starvation; free-slot grants restart the count.
      if (c_gnt && D_REQ) begin
        if (wait_cnt_q >= WAIT_LAST) begin
          own_d       = OWN_D;
          wait_cnt_d  = '0;
          burst_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end else begin
        wait_cnt_d = '0;
      end
    end else begin
      wait_cnt_d = '0;
      if (!D_REQ || burst_cnt_q >= BURST_LAST) begin
        own_d       = OWN_C;
        burst_cnt_d = '0;
      end else begin
        burst_cnt_d = burst_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      own_q       <= OWN_C;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      own_q       <= own_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign C_GNT   = c_gnt;
  assign D_GNT   = d_gnt;
  assign C_RDY   = c_gnt | ~C_REQ;
  assign RD_DATA = MEM_DOUT;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter: two instances (4/8 and 1/1 limits) driven
// with identical requests and checked against a cycle-level ownership model plus a memory image.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        r, c_req, c_we, d_req, d_we;
  logic [15:0] c_addr, d_addr;
  logic [7:0]  c_din, d_din;

  logic        a_c_gnt, a_c_rdy, a_d_gnt, a_mem_we;
  logic [7:0]  a_rd_data, a_mem_din, a_mem_dout;
  logic [15:0] a_mem_addr;
  logic        b_c_gnt, b_c_rdy, b_d_gnt, b_mem_we;
  logic [7:0]  b_rd_data, b_mem_din, b_mem_dout;
  logic [15:0] b_mem_addr;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  typedef struct {
    bit          d_owns;
    int unsigned blocked;
    int unsigned burst;
  } mdl_t;

  mdl_t ma, mb;

  always #5 clk = ~clk;

  assign a_mem_dout = mem[a_mem_addr];
  assign b_mem_dout = b_mem_addr[7:0] ^ 8'h5A;

  mem_arbiter #(.AW(16), .DW(8), .MAX_WAIT(4), .BURST_LEN(8)) u_a (
    .CLK(clk), .R(r),
    .C_REQ(c_req), .C_WE(c_we), .C_ADDR(c_addr), .C_DIN(c_din), .C_GNT(a_c_gnt), .C_RDY(a_c_rdy),
    .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_DIN(d_din), .D_GNT(a_d_gnt),
    .RD_DATA(a_rd_data), .MEM_ADDR(a_mem_addr), .MEM_WE(a_mem_we), .MEM_DIN(a_mem_din),
    .MEM_DOUT(a_mem_dout)
  );

  mem_arbiter #(.AW(16), .DW(8), .MAX_WAIT(1), .BURST_LEN(1)) u_b (
    .CLK(clk), .R(r),
    .C_REQ(c_req), .C_WE(c_we), .C_ADDR(c_addr), .C_DIN(c_din), .C_GNT(b_c_gnt), .C_RDY(b_c_rdy),
    .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_DIN(d_din), .D_GNT(b_d_gnt),
    .RD_DATA(b_rd_data), .MEM_ADDR(b_mem_addr), .MEM_WE(b_mem_we), .MEM_DIN(b_mem_din),
    .MEM_DOUT(b_mem_dout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  // Who gets the bus this cycle: the owner if it asks, otherwise the other port if it asks.
  function automatic void grants(input mdl_t m, input bit rr, input bit cq, input bit dq,
                                 output bit cg, output bit dg);
    cg = 1'b0;
    dg = 1'b0;
    if (!rr) begin
      if (m.d_owns) begin dg = dq; cg = cq && !dq; end
      else          begin cg = cq; dg = dq && !cq; end
    end
  endfunction

  function automatic mdl_t next_m(input mdl_t m, input int unsigned mw, input int unsigned bl,
                                  input bit rr, input bit cg, input bit dq);
    mdl_t n = m;
    if (rr) begin
      n.d_owns = 1'b0; n.blocked = 0; n.burst = 0;
    end else if (!m.d_owns) begin
      if (cg && dq) begin
        n.blocked = m.blocked + 1;
        if (n.blocked == mw) begin n.d_owns = 1'b1; n.blocked = 0; n.burst = 0; end
      end else begin
        n.blocked = 0;
      end
    end else if (!dq) begin
      n.d_owns = 1'b0; n.burst = 0;
    end else begin
      n.burst = m.burst + 1;
      if (n.burst == bl) begin n.d_owns = 1'b0; n.burst = 0; end
    end
    return n;
  endfunction

  // {we, addr, din} the granted port should place on the memory port.
  function automatic logic [24:0] bus(input bit cg, input bit dg);
    if (cg)      return {c_we, c_addr, c_din};
    else if (dg) return {d_we, d_addr, d_din};
    else         return {1'b0, c_addr, 8'h00};
  endfunction

  task automatic cycle(input bit rr, input bit cq, input bit cw, input logic [15:0] ca,
                       input logic [7:0] cd, input bit dq, input bit dw,
                       input logic [15:0] da, input logic [7:0] dd);
    bit          acg, adg, bcg, bdg;
    logic [24:0] ea, eb;
    logic        wr_we;
    logic [15:0] wr_addr;
    logic [7:0]  wr_din;
    @(negedge clk);
    r = rr; c_req = cq; c_we = cw; c_addr = ca; c_din = cd;
    d_req = dq; d_we = dw; d_addr = da; d_din = dd;
    #1;
    grants(ma, rr, cq, dq, acg, adg);
    grants(mb, rr, cq, dq, bcg, bdg);
    ea = bus(acg, adg);
    eb = bus(bcg, bdg);
    chk("a_c_gnt",    32'(a_c_gnt),    32'(acg));
    chk("a_d_gnt",    32'(a_d_gnt),    32'(adg));
    chk("a_c_rdy",    32'(a_c_rdy),    32'(acg || !cq));
    chk("a_excl",     32'(a_c_gnt & a_d_gnt), 32'd0);
    chk("a_mem_we",   32'(a_mem_we),   32'(ea[24]));
    chk("a_mem_addr", 32'(a_mem_addr), 32'(ea[23:8]));
    chk("a_mem_din",  32'(a_mem_din),  32'(ea[7:0]));
    chk("a_rd_data",  32'(a_rd_data),  32'(ref_mem[ea[23:8]]));
    chk("b_c_gnt",    32'(b_c_gnt),    32'(bcg));
    chk("b_d_gnt",    32'(b_d_gnt),    32'(bdg));
    chk("b_c_rdy",    32'(b_c_rdy),    32'(bcg || !cq));
    chk("b_mem_we",   32'(b_mem_we),   32'(eb[24]));
    chk("b_mem_addr", 32'(b_mem_addr), 32'(eb[23:8]));
    chk("b_rd_data",  32'(b_rd_data),  32'(eb[15:8] ^ 8'h5A));
    wr_we = a_mem_we; wr_addr = a_mem_addr; wr_din = a_mem_din;
    @(posedge clk);
    if (wr_we) mem[wr_addr] = wr_din;
    if (ea[24]) ref_mem[ea[23:8]] = ea[7:0];
    ma = next_m(ma, 4, 8, rr, acg, dq);
    mb = next_m(mb, 1, 1, rr, bcg, dq);
  endtask

  task automatic dual(input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      cycle(1'b0, 1'b1, 1'b0, 16'h0200 + 16'(i % 16), 8'h00,
            1'b1, 1'b1, 16'h0210 + 16'(i % 16), 8'(i));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'(i) ^ 8'(i >> 8);
      ref_mem[i] = 8'(i) ^ 8'(i >> 8);
    end
    ma = '{d_owns: 1'b0, blocked: 0, burst: 0};
    mb = ma;
    r = 1'b1; c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_din = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_din = '0;

    // reset: both requesting, nothing granted
    cycle(1'b1, 1'b1, 1'b1, 16'h1234, 8'h11, 1'b1, 1'b1, 16'h0300, 8'h22);
    cycle(1'b1, 1'b0, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    // cpu read, then DMA free-slot write and cpu read-back
    cycle(1'b0, 1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 1'b1, 1'b1, 16'h0200, 8'hA5);
    cycle(1'b0, 1'b1, 1'b0, 16'h0200, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    // saturated dual requests: 4 C / 8 D rhythm on u_a, strict alternation on u_b
    dual(30);
    // drop D_REQ after 3 burst grants while the cpu keeps asking
    cycle(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    dual(4 + 3);
    for (int unsigned i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 1'b0, 16'h0210, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    // reset in the middle of a burst, then the full wait again
    dual(4 + 5);
    cycle(1'b1, 1'b1, 1'b1, 16'h0201, 8'h77, 1'b1, 1'b1, 16'h0211, 8'h88);
    dual(14);

    for (int unsigned ph = 0; ph < 4; ph++) begin
      for (int unsigned i = 0; i < 150; i++) begin
        cycle($urandom_range(63) == 0,
              $urandom_range(3) < ph + 1, 1'($urandom), 16'h0200 + 16'($urandom_range(31)),
              8'($urandom),
              $urandom_range(3) < 4 - ph, 1'($urandom), 16'h0200 + 16'($urandom_range(31)),
              8'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
